// File: rtl/redirect_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : redirect_ctrl_if                                                |
// | Brief    : Request/redirect bundle between hazard units, redirect_ctrl and |
// |            the PC mux. Optional macro: REDIRECT_STATS_EN (stat outputs).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface redirect_ctrl_if;
  logic        stall;
  logic        exc_req;
  logic [31:0] exc_vec;
  logic        br_req;
  logic [31:0] br_target;
  logic        jr_req;
  logic [31:0] jr_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        busy;
`ifdef REDIRECT_STATS_EN
  logic [15:0] stat_exc;
  logic [15:0] stat_br;
  logic [15:0] stat_jr;

  modport master (
    output stall, exc_req, exc_vec, br_req, br_target, jr_req, jr_target,
    input  redirect_valid, redirect_pc, flush_if, flush_id, flush_ex, busy,
    input  stat_exc, stat_br, stat_jr
  );
  modport slave (
    input  stall, exc_req, exc_vec, br_req, br_target, jr_req, jr_target,
    output redirect_valid, redirect_pc, flush_if, flush_id, flush_ex, busy,
    output stat_exc, stat_br, stat_jr
  );
`else
  modport master (
    output stall, exc_req, exc_vec, br_req, br_target, jr_req, jr_target,
    input  redirect_valid, redirect_pc, flush_if, flush_id, flush_ex, busy
  );
  modport slave (
    input  stall, exc_req, exc_vec, br_req, br_target, jr_req, jr_target,
    output redirect_valid, redirect_pc, flush_if, flush_id, flush_ex, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/redirect_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : redirect_ctrl                                                   |
// | Brief    : Priority arbiter for PC redirects (exc > br > jr) with a        |
// |            registered target and flush sequencing.                         |
// |            Optional macro: REDIRECT_STATS_EN (per-source issue counters).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rsta,
  redirect_ctrl_if.slave bus
);

  // Source codes are ordered so that a numeric compare gives priority.
  localparam logic [1:0] c_SRC_NONE = 2'd0;
  localparam logic [1:0] c_SRC_JR   = 2'd1;
  localparam logic [1:0] c_SRC_BR   = 2'd2;
  localparam logic [1:0] c_SRC_EXC  = 2'd3;
  localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;

  state_t      r_state;
  logic [1:0]  r_src;
  logic [31:0] r_target;
  logic [3:0]  r_cnt;
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_flush_if;
  logic        r_flush_id;
  logic        r_flush_ex;
  logic        r_busy;

  logic [1:0]  w_req_src;
  logic [31:0] w_req_target;
  logic [1:0]  w_hold_src;
  logic [31:0] w_hold_target;
  logic        w_issue;
  logic [1:0]  w_issue_src;
  logic [31:0] w_issue_target;

  always_comb begin
    w_req_src    = c_SRC_NONE;
    w_req_target = 32'h0;
    if (bus.exc_req) begin
      w_req_src    = c_SRC_EXC;
      w_req_target = bus.exc_vec & 32'hFFFF_FFFC;
    end else if (bus.br_req) begin
      w_req_src    = c_SRC_BR;
      w_req_target = bus.br_target & 32'hFFFF_FFFC;
    end else if (bus.jr_req) begin
      w_req_src    = c_SRC_JR;
      w_req_target = bus.jr_target & 32'hFFFF_FFFC;
    end
  end

  // A held request is replaced only by a strictly higher-priority one.
  assign w_hold_src    = (w_req_src > r_src) ? w_req_src    : r_src;
  assign w_hold_target = (w_req_src > r_src) ? w_req_target : r_target;

  always_comb begin
    w_issue        = 1'b0;
    w_issue_src    = c_SRC_NONE;
    w_issue_target = r_target;
    case (r_state)
      S_IDLE: begin
        w_issue        = (w_req_src != c_SRC_NONE) && !bus.stall;
        w_issue_src    = w_req_src;
        w_issue_target = w_req_target;
      end
      S_HOLD: begin
        w_issue        = !bus.stall;
        w_issue_src    = w_hold_src;
        w_issue_target = w_hold_target;
      end
      S_FLUSH: begin
        // Branches and jumps seen here belong to squashed instructions.
        w_issue        = bus.exc_req && !bus.stall;
        w_issue_src    = c_SRC_EXC;
        w_issue_target = w_req_target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsta) begin
      r_state    <= S_IDLE;
      r_src      <= c_SRC_NONE;
      r_target   <= 32'h0;
      r_cnt      <= 4'd0;
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_flush_if <= 1'b0;
      r_flush_id <= 1'b0;
      r_flush_ex <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_issue) begin
        r_state    <= S_FLUSH;
        r_src      <= c_SRC_NONE;
        r_target   <= w_issue_target;
        r_cnt      <= c_FLUSH_LOAD;
        r_valid    <= 1'b1;
        r_pc       <= w_issue_target;
        r_flush_if <= 1'b1;
        r_flush_id <= 1'b1;
        r_flush_ex <= (w_issue_src == c_SRC_EXC);
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_req_src != c_SRC_NONE) begin
              r_state  <= S_HOLD;
              r_src    <= w_req_src;
              r_target <= w_req_target;
              r_busy   <= 1'b1;
            end
          end
          S_HOLD: begin
            r_src    <= w_hold_src;
            r_target <= w_hold_target;
          end
          S_FLUSH: begin
            if (bus.exc_req) begin
              r_state    <= S_HOLD;
              r_src      <= c_SRC_EXC;
              r_target   <= w_req_target;
              r_flush_if <= 1'b0;
              r_flush_id <= 1'b0;
              r_flush_ex <= 1'b0;
            end else if (r_cnt <= 4'd1) begin
              r_state    <= S_IDLE;
              r_flush_if <= 1'b0;
              r_flush_id <= 1'b0;
              r_flush_ex <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.redirect_valid = r_valid;
  assign bus.redirect_pc    = r_pc;
  assign bus.flush_if       = r_flush_if;
  assign bus.flush_id       = r_flush_id;
  assign bus.flush_ex       = r_flush_ex;
  assign bus.busy           = r_busy;

`ifdef REDIRECT_STATS_EN
  logic [15:0] r_stat_exc;
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_jr;

  always_ff @(posedge clk) begin
    if (rsta) begin
      r_stat_exc <= 16'h0;
      r_stat_br  <= 16'h0;
      r_stat_jr  <= 16'h0;
    end else if (w_issue) begin
      case (w_issue_src)
        c_SRC_EXC: if (r_stat_exc != 16'hFFFF) r_stat_exc <= r_stat_exc + 16'd1;
        c_SRC_BR:  if (r_stat_br  != 16'hFFFF) r_stat_br  <= r_stat_br  + 16'd1;
        c_SRC_JR:  if (r_stat_jr  != 16'hFFFF) r_stat_jr  <= r_stat_jr  + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.stat_exc = r_stat_exc;
  assign bus.stat_br  = r_stat_br;
  assign bus.stat_jr  = r_stat_jr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_redirect_ctrl                                                |
// | Brief    : Directed self-checking bench for redirect_ctrl.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_redirect_ctrl;

  localparam logic [31:0] c_RESET_PC = 32'h0000_1000;

  logic clk;
  logic rsta;
  int   checks;
  int   failures;
  int   rv_count;
  int   rv_base;

  redirect_ctrl_if bus ();

  redirect_ctrl #(
    .FLUSH_CYCLES (2),
    .RESET_PC     (c_RESET_PC)
  ) dut (
    .clk  (clk),
    .rsta (rsta),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rsta && bus.redirect_valid) rv_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle_inputs();
    bus.stall   = 1'b0;
    bus.exc_req = 1'b0;
    bus.br_req  = 1'b0;
    bus.jr_req  = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rv_count  = 0;
    rsta      = 1'b1;
    idle_inputs();
    bus.exc_vec   = 32'h0;
    bus.br_target = 32'h0;
    bus.jr_target = 32'h0;
    step();
    step();
    rsta = 1'b0;

    // Reset state
    chk("rst_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_pc",    bus.redirect_pc,         c_RESET_PC);
    chk("rst_flush", {29'd0, bus.flush_if, bus.flush_id, bus.flush_ex}, 32'd0);
    chk("rst_busy",  32'(bus.busy),           32'd0);
`ifdef REDIRECT_STATS_EN
    chk("rst_stats", {bus.stat_exc, bus.stat_br | bus.stat_jr}, 32'd0);
`endif

    // Single branch, target realigned
    bus.br_req = 1'b1; bus.br_target = 32'h0040_0123;
    step();
    bus.br_req = 1'b0;
    chk("br_valid", 32'(bus.redirect_valid), 32'd1);
    chk("br_pc",    bus.redirect_pc,         32'h0040_0120);
    chk("br_fl1",   {29'd0, bus.flush_if, bus.flush_id, bus.flush_ex}, 32'b110);
    step();
    chk("br_pulse", 32'(bus.redirect_valid), 32'd0);
    chk("br_fl2",   {29'd0, bus.flush_if, bus.flush_id, bus.flush_ex}, 32'b110);
    step();
    chk("br_fl_end", {29'd0, bus.flush_if, bus.flush_id, bus.flush_ex}, 32'b000);
    chk("br_idle",  32'(bus.busy),   32'd0);
    chk("br_hold_pc", bus.redirect_pc, 32'h0040_0120);

    // All three together: exception wins
    rv_base = rv_count;
    bus.exc_req = 1'b1; bus.exc_vec   = 32'h8000_0180;
    bus.br_req  = 1'b1; bus.br_target = 32'h0000_2220;
    bus.jr_req  = 1'b1; bus.jr_target = 32'h0000_3330;
    step();
    idle_inputs();
    chk("all_pc",  bus.redirect_pc, 32'h8000_0180);
    chk("all_fl",  {29'd0, bus.flush_if, bus.flush_id, bus.flush_ex}, 32'b111);
    step();
    step();
    step();
    chk("all_count", 32'(rv_count - rv_base), 32'd1);
    chk("all_idle",  32'(bus.busy), 32'd0);

    // jr held under stall, overwritten by br
    rv_base = rv_count;
    bus.stall = 1'b1; bus.jr_req = 1'b1; bus.jr_target = 32'h0000_2004;
    step();
    chk("hold_busy", 32'(bus.busy), 32'd1);
    bus.br_req = 1'b1; bus.br_target = 32'h0000_300B;
    step();
    bus.br_req = 1'b0;
    step();
    chk("hold_none", 32'(rv_count - rv_base), 32'd0);
    bus.stall = 1'b0; bus.jr_req = 1'b0;
    step();
    chk("hold_valid", 32'(bus.redirect_valid), 32'd1);
    chk("hold_pc",    bus.redirect_pc,         32'h0000_3008);
    chk("hold_flex",  32'(bus.flush_ex),       32'd0);
    step();
    step();
    step();
    chk("hold_count", 32'(rv_count - rv_base), 32'd1);

    // br redirect preempted by exc in flush; jr in flush ignored
    rv_base = rv_count;
    bus.br_req = 1'b1; bus.br_target = 32'h0000_4000;
    step();
    bus.br_req = 1'b0;
    bus.exc_req = 1'b1; bus.exc_vec = 32'h0000_0202;
    step();
    bus.exc_req = 1'b0;
    chk("pre_valid", 32'(bus.redirect_valid), 32'd1);
    chk("pre_pc",    bus.redirect_pc,         32'h0000_0200);
    chk("pre_flex",  32'(bus.flush_ex),       32'd1);
    bus.jr_req = 1'b1; bus.jr_target = 32'h0000_5000;
    step();
    chk("pre_reload", {30'd0, bus.flush_if, bus.busy}, 32'b11);
    step();
    bus.jr_req = 1'b0;
    chk("pre_end", {30'd0, bus.flush_if, bus.busy}, 32'b00);
    step();
    step();
    chk("pre_count", 32'(rv_count - rv_base), 32'd2);
    chk("pre_pc_held", bus.redirect_pc, 32'h0000_0200);

    // exc under stall in flush parks in HOLD with flush dropped
    rv_base = rv_count;
    bus.br_req = 1'b1; bus.br_target = 32'h0000_6000;
    step();
    bus.br_req = 1'b0;
    bus.exc_req = 1'b1; bus.exc_vec = 32'h0000_0300; bus.stall = 1'b1;
    step();
    chk("fh_state", {29'd0, bus.flush_if, bus.redirect_valid, bus.busy}, 32'b001);
    bus.exc_req = 1'b0; bus.stall = 1'b0;
    step();
    chk("fh_valid", {30'd0, bus.redirect_valid, bus.flush_ex}, 32'b11);
    chk("fh_pc",    bus.redirect_pc, 32'h0000_0300);
    step();
    step();
    step();
    chk("fh_count", 32'(rv_count - rv_base), 32'd2);
`ifdef REDIRECT_STATS_EN
    chk("st_br_run",  32'(bus.stat_br),  32'd4);
    chk("st_exc_run", 32'(bus.stat_exc), 32'd3);
    chk("st_jr_run",  32'(bus.stat_jr),  32'd0);
`endif

    // Reset while holding discards the request
    rv_base = rv_count;
    bus.stall = 1'b1; bus.jr_req = 1'b1; bus.jr_target = 32'h0000_7000;
    step();
    chk("rh_busy", 32'(bus.busy), 32'd1);
    rsta = 1'b1; bus.stall = 1'b0; bus.jr_req = 1'b0;
    step();
    chk("rh_busy0", 32'(bus.busy),  32'd0);
    chk("rh_pc",    bus.redirect_pc, c_RESET_PC);
    rsta = 1'b0;
    step();
    step();
    step();
    chk("rh_none", 32'(rv_count - rv_base), 32'd0);

`ifdef REDIRECT_STATS_EN
    chk("st_clear", {bus.stat_exc, bus.stat_br | bus.stat_jr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.br_req = 1'b1; bus.br_target = 32'h0000_8000 + 32'(i * 16);
      step();
      bus.br_req = 1'b0;
      step();
      step();
    end
    bus.exc_req = 1'b1; bus.exc_vec = 32'h0000_0400;
    step();
    bus.exc_req = 1'b0;
    step();
    step();
    chk("st_br",  32'(bus.stat_br),  32'd3);
    chk("st_exc", 32'(bus.stat_exc), 32'd1);
    chk("st_jr",  32'(bus.stat_jr),  32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
